// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the serial packet transmitter.
package serial_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         PKT_LEN           = 6;
    localparam int         BITS_PER_FRAME    = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_BYTE = 2'd1,
        NEXT_BYTE = 2'd2
    } state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serialiser for one byte; a load in the final stop-bit cycle chains the
// next frame with no idle gap.
module uart_byte_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       TX,
    output logic       done
);

    localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     STOP_IDX  = 4'(BITS_PER_FRAME - 1);

    logic          busy;
    logic [3:0]    bit_idx;
    logic [TW-1:0] bit_timer;
    logic [7:0]    shreg;

    assign done = busy && (bit_idx == STOP_IDX) && (bit_timer == LAST_TICK);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            bit_idx   <= '0;
            bit_timer <= '0;
            shreg     <= '0;
            TX        <= 1'b1;
        end else if (load) begin
            busy      <= 1'b1;
            bit_idx   <= '0;
            bit_timer <= '0;
            shreg     <= byte_in;
            TX        <= 1'b0;
        end else if (busy) begin
            if (bit_timer == LAST_TICK) begin
                bit_timer <= '0;
                if (bit_idx == STOP_IDX) begin
                    busy <= 1'b0;
                    TX   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    // bit_idx 0..7 selects data bit bit_idx for the next slot; 8 leads into the stop bit
                    TX      <= (bit_idx == STOP_IDX - 4'd1) ? 1'b1 : shreg[bit_idx[2:0]];
                end
            end else begin
                bit_timer <= bit_timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_packet_tx.sv
// Sends SYNC, 3 address bytes, a data byte and an XOR checksum as back-to-back
// 8N1 frames on TX.
module serial_packet_tx
    import serial_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  datain,
    input  logic [23:0] addrin,
    output logic        ready,
    output logic        TX
);

    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

    state_t      state;
    logic [2:0]  byte_idx;
    logic [2:0]  next_idx;
    logic [23:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  csum;
    logic [7:0]  next_byte;
    logic [7:0]  byte_in;
    logic        accept;
    logic        advance;
    logic        byte_load;
    logic        byte_done;

    assign accept    = ready && start;
    assign next_idx  = byte_idx + 3'd1;
    // The next byte is loaded on the edge that ends the stop bit, so frames abut.
    assign advance   = (state == SEND_BYTE) && byte_done && (byte_idx < LAST_IDX);
    assign byte_load = accept || advance;
    assign byte_in   = accept ? SYNC_BYTE : next_byte;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_byte = csum;
        case (next_idx)
            3'd1:    next_byte = addr_q[23:16];
            3'd2:    next_byte = addr_q[15:8];
            3'd3:    next_byte = addr_q[7:0];
            3'd4:    next_byte = data_q;
            default: next_byte = csum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            csum     <= '0;
            ready    <= 1'b1;
        end else if (accept) begin
            state    <= SEND_BYTE;
            byte_idx <= '0;
            addr_q   <= addrin;
            data_q   <= datain;
            csum     <= SYNC_BYTE;
            ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                SEND_BYTE: begin
                    if (byte_done) begin
                        state <= NEXT_BYTE;
                        if (byte_idx < LAST_IDX) begin
                            byte_idx <= next_idx;
                            if (next_idx < LAST_IDX)
                                csum <= csum ^ next_byte;
                        end else begin
                            ready <= 1'b1;
                        end
                    end
                end
                // With ready high the checksum frame has finished; otherwise the next frame is already running.
                NEXT_BYTE: state <= (byte_idx == LAST_IDX && ready) ? IDLE : SEND_BYTE;
                default:   state <= IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (byte_load),
        .byte_in (byte_in),
        .TX      (TX),
        .done    (byte_done)
    );

endmodule

// File: doc/serial_packet_tx.md
SERIAL_PACKET_TX -- requirements
Module: serial_packet_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, the number of clk cycles per UART bit (25 MHz / 115200 baud).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, the first byte of every packet.
REQ-003 SHALL have port clk, input, 1 bit, the single clock (pixclk domain); all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to send one packet.
REQ-006 SHALL have port datain, input, 8 bits, the pixel byte to send.
REQ-007 SHALL have port addrin, input, 24 bits, the pixel address to send.
REQ-008 SHALL have port ready, output, 1 bit, high when idle and able to accept start.
REQ-009 SHALL have port TX, output, 1 bit, the UART line: idle high, 8N1, LSB first.

Function
REQ-010 SHALL send each packet as 6 bytes in this order: SYNC_BYTE, addrin[23:16], addrin[15:8], addrin[7:0], datain, checksum.
REQ-011 SHALL compute checksum as the bitwise XOR of the 5 preceding packet bytes.
REQ-012 SHALL accept start only when ready=1, capturing datain and addrin into internal registers on that same edge.
REQ-013 SHALL ignore start while ready=0: no queuing, no effect on the packet in flight.
REQ-014 SHALL drive ready=0 from the cycle after acceptance until the final stop bit completes.
REQ-015 SHALL drive the start bit (TX=0) on TX starting on the cycle after acceptance.
REQ-016 SHALL frame each byte as: start bit 0, data bits 0..7, stop bit 1, each held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL send the bytes back-to-back, with the next start bit immediately after the previous stop bit and no extra idle.
REQ-018 SHALL make a packet occupy exactly 60*CLKS_PER_BIT cycles of ready=0.
REQ-019 SHALL return ready to 1 on the first cycle after the last stop-bit period.
REQ-020 SHALL let a start on that first ready cycle begin the next packet with zero extra gap.
REQ-021 SHALL use top-level FSM states IDLE, SEND_BYTE and NEXT_BYTE, with these transitions:
- IDLE -> SEND_BYTE on an accepted start;
- SEND_BYTE -> NEXT_BYTE when the byte sub-module signals done;
- NEXT_BYTE -> SEND_BYTE while byte index < 5;
- NEXT_BYTE -> IDLE when byte index = 5.
REQ-022 SHALL use a 3-bit byte index running 0..5, never wrapping past 5.
REQ-023 SHALL use a bit-timer counter sized to $clog2(CLKS_PER_BIT) bits that wraps at CLKS_PER_BIT-1 to 0.
REQ-024 SHALL use a 4-bit bit index running 0..9 (start, 8 data, stop).
REQ-025 SHALL hold TX at 1 whenever the FSM is in IDLE.
REQ-026 SHALL ignore changes to datain and addrin after acceptance; the packet content is the captured values.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set TX=1, ready=1, FSM=IDLE, and clear byte index, bit index, bit timer and the checksum accumulator.
REQ-028 SHALL abort a packet immediately when reset is asserted mid-packet (TX=1 on the next cycle), with no partial byte completion.
REQ-029 SHALL give reset priority over a simultaneous start; that start is dropped.

Structure
REQ-030 SHALL place the SYNC_BYTE default, the packet length constant 6, the bits-per-frame constant 10 and the FSM state typedef in shared package serial_pkg.
REQ-031 SHALL implement single-byte 8N1 serialisation in sub-module uart_byte_tx, with ports clk, reset, load, byte_in[7:0], TX, done.
REQ-032 SHALL have uart_byte_tx pulse done for one cycle at the end of the stop bit.
REQ-033 SHALL keep packet sequencing and checksum logic in serial_packet_tx itself.

Verification (CLKS_PER_BIT=4)
REQ-034 SHALL cover basic packet: start with addrin=24'h012345, datain=8'h3C -> TX bytes A5 01 23 45 3C FE, each correctly framed; ready low for exactly 240 cycles.
REQ-035 SHALL cover back-to-back packets: a second start (addr 24'h000001, data 8'hFF) on the first ready cycle -> start bit on the next cycle; bytes A5 00 00 01 FF 5B.
REQ-036 SHALL cover busy ignore: start pulses at cycles 10 and 100 of a packet -> exactly one packet is sent, and ready returns at cycle 240.
REQ-037 SHALL cover reset mid-packet: reset asserted during byte 3, bit 4 -> TX=1 and ready=1 on the next cycle; a following start sends a complete, correct packet.
REQ-038 SHALL cover input stability: datain and addrin changed one cycle after acceptance -> the packet carries the originally captured values.
REQ-039 SHALL cover reset precedence: start and reset asserted in the same cycle -> no packet is sent; TX stays 1.
